// File: rtl/encrypt_ctrl.sv
// Encrypt sequencer: walks public-key rows and chunks, masks sample lanes with
// the captured subset, drives the accumulator and buffers per-row ciphertext.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing key reads, row-major with chunk innermost
// DRAIN | last read issued, final data being presented
// FLUSH | enc_en low and row back to 0 so the last row is emitted
// WAIT  | waiting for the last row capture
module encrypt_ctrl #(
  parameter int CIPHERTEXT_WIDTH = 32,
  parameter int DIMENSION        = 128,
  parameter int DIM_WIDTH        = 7,
  parameter int BIG_N            = 30,
  parameter int PARALLEL         = 2,
  localparam int CHUNKS  = (BIG_N + 2*PARALLEL - 1) / (2*PARALLEL),
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [BIG_N-1:0]                           subset,
  output logic                                       busy,
  output logic                                       mem_req,
  output logic [DIM_WIDTH:0]                         mem_row,
  output logic [CHUNK_W-1:0]                         mem_chunk,
  input  logic [2*PARALLEL*CIPHERTEXT_WIDTH-1:0]     mem_rdata,
  output logic                                       enc_en,
  output logic [DIM_WIDTH:0]                         enc_row,
  output logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0]  enc_op1,
  output logic [PARALLEL-1:0][CIPHERTEXT_WIDTH-1:0]  enc_op2,
  output logic                                       enc_done,
  input  logic [CIPHERTEXT_WIDTH-1:0]                ct_in,
  output logic                                       ct_valid,
  input  logic                                       ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0]                ct_data,
  output logic [DIM_WIDTH:0]                         ct_row
);

  localparam int W     = CIPHERTEXT_WIDTH;
  localparam int ROW_W = DIM_WIDTH + 1;
  localparam int LANES = 2 * PARALLEL;
  localparam int SEL_N = CHUNKS * LANES;
  localparam int SEL_W = (SEL_N > 1) ? $clog2(SEL_N) : 1;
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(DIMENSION);
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
  localparam logic [W-1:0]       MSB        = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [BIG_N-1:0]   subset_q, subset_d;
  logic [ROW_W-1:0]   iss_row_q, iss_row_d;
  logic [CHUNK_W-1:0] iss_chunk_q, iss_chunk_d;
  logic               rvalid_q, rvalid_d;
  logic [CHUNK_W-1:0] rchunk_q, rchunk_d;
  logic               en_q, en_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               b1_q, b1_d, b2_q, b2_d;
  logic [ROW_W-1:0]   b1_row_q, b1_row_d, b2_row_q, b2_row_d;
  logic [W-1:0]       fdata_q [2];
  logic [W-1:0]       fdata_d [2];
  logic [ROW_W-1:0]   frow_q [2];
  logic [ROW_W-1:0]   frow_d [2];
  logic               wr_q, wr_d, rd_q, rd_d;
  logic [1:0]         cnt_q, cnt_d;

  logic [2:0]         occ;
  logic               room, issue, go_flush, push, pop;
  logic [SEL_N-1:0]   sel_vec;
  logic [SEL_W-1:0]   sel_idx;
  logic [LANES-1:0][W-1:0] lanes;

  // A row boundary costs one FIFO slot from the moment it is presented until
  // its word is captured, so occupancy counts both.
  always_comb begin
    occ      = {1'b0, cnt_q} + {2'b0, b1_q} + {2'b0, b2_q};
    room     = (occ < 3'd2);
    issue    = (state_q == S_RUN) && ((iss_chunk_q != '0) || (iss_row_q == '0) || room);
    go_flush = (state_q == S_DRAIN) && room;

    state_d     = state_q;
    subset_d    = subset_q;
    iss_row_d   = iss_row_q;
    iss_chunk_d = iss_chunk_q;
    rvalid_d    = issue;
    rchunk_d    = iss_chunk_q;
    en_d        = en_q;
    row_d       = row_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          subset_d    = subset;
          iss_row_d   = '0;
          iss_chunk_d = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          en_d  = 1'b1;
          row_d = iss_row_q;
          if (iss_chunk_q == LAST_CHUNK) begin
            iss_chunk_d = '0;
            if (iss_row_q == LAST_ROW) state_d = S_DRAIN;
            else iss_row_d = iss_row_q + ROW_W'(1);
          end else begin
            iss_chunk_d = iss_chunk_q + CHUNK_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (go_flush) begin
          state_d = S_FLUSH;
          en_d    = 1'b0;
          row_d   = '0;
        end
      end
      S_FLUSH: state_d = S_WAIT;
      S_WAIT:  if (!b1_q && !b2_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    b1_d     = (row_d != row_q);
    b1_row_d = row_q;
    b2_d     = b1_q;
    b2_row_d = b1_row_q;

    push    = b2_q;
    pop     = (cnt_q != 2'd0) && ct_ready;
    fdata_d = fdata_q;
    frow_d  = frow_q;
    if (push) begin
      fdata_d[wr_q] = ct_in;
      frow_d[wr_q]  = b2_row_q;
    end
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Lanes with no returning data, an unselected sample or a sample past BIG_N
  // carry MSB=1 so the accumulator skips them.
  always_comb begin
    sel_vec              = '0;
    sel_vec[BIG_N-1:0]   = subset_q;
    sel_idx              = '0;
    lanes                = '0;
    for (int j = 0; j < LANES; j++) begin
      sel_idx  = SEL_W'(int'(rchunk_q) * LANES + j);
      lanes[j] = mem_rdata[j*W +: W];
      if (!rvalid_q)              lanes[j] = MSB;
      else if (!sel_vec[sel_idx]) lanes[j] = lanes[j] | MSB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      subset_q    <= '0;
      iss_row_q   <= '0;
      iss_chunk_q <= '0;
      rvalid_q    <= 1'b0;
      rchunk_q    <= '0;
      en_q        <= 1'b0;
      row_q       <= '0;
      b1_q        <= 1'b0;
      b2_q        <= 1'b0;
      b1_row_q    <= '0;
      b2_row_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        fdata_q[i] <= '0;
        frow_q[i]  <= '0;
      end
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      subset_q    <= subset_d;
      iss_row_q   <= iss_row_d;
      iss_chunk_q <= iss_chunk_d;
      rvalid_q    <= rvalid_d;
      rchunk_q    <= rchunk_d;
      en_q        <= en_d;
      row_q       <= row_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      b1_row_q    <= b1_row_d;
      b2_row_q    <= b2_row_d;
      fdata_q     <= fdata_d;
      frow_q      <= frow_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_req   = issue;
  assign mem_row   = iss_row_q;
  assign mem_chunk = iss_chunk_q;
  assign enc_en    = en_q;
  assign enc_row   = row_q;
  assign enc_op1   = lanes[PARALLEL-1:0];
  assign enc_op2   = lanes[LANES-1:PARALLEL];
  assign enc_done  = (state_q == S_FLUSH);
  assign ct_valid  = (cnt_q != 2'd0);
  assign ct_data   = fdata_q[rd_q];
  assign ct_row    = frow_q[rd_q];

endmodule

// File: tb/tb_encrypt_ctrl.sv
// Bench for encrypt_ctrl: key-memory and accumulator models around the default
// instance plus a single-chunk instance, with a ciphertext scoreboard.
module tb_encrypt_ctrl;

  localparam logic [63:0] IDLE_LANES = 64'h8000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic         start, busy, mem_req, enc_en, enc_done, ct_valid, ct_ready;
  logic [29:0]  subset;
  logic [7:0]   mem_row, enc_row, ct_row;
  logic [2:0]   mem_chunk;
  logic [127:0] mem_rdata;
  logic [1:0][31:0] enc_op1, enc_op2;
  logic [31:0]  ct_in, ct_data;

  encrypt_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .subset(subset), .busy(busy),
    .mem_req(mem_req), .mem_row(mem_row), .mem_chunk(mem_chunk), .mem_rdata(mem_rdata),
    .enc_en(enc_en), .enc_row(enc_row), .enc_op1(enc_op1), .enc_op2(enc_op2),
    .enc_done(enc_done), .ct_in(ct_in), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .ct_data(ct_data), .ct_row(ct_row)
  );

  // single-chunk instance
  logic         start_b, busy_b, mem_req_b, enc_en_b, enc_done_b, ct_valid_b, ct_ready_b;
  logic [3:0]   subset_b;
  logic [7:0]   mem_row_b, enc_row_b, ct_row_b;
  logic [0:0]   mem_chunk_b;
  logic [127:0] mem_rdata_b;
  logic [1:0][31:0] enc_op1_b, enc_op2_b;
  logic [31:0]  ct_in_b, ct_data_b;

  encrypt_ctrl #(.BIG_N(4), .PARALLEL(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .subset(subset_b), .busy(busy_b),
    .mem_req(mem_req_b), .mem_row(mem_row_b), .mem_chunk(mem_chunk_b), .mem_rdata(mem_rdata_b),
    .enc_en(enc_en_b), .enc_row(enc_row_b), .enc_op1(enc_op1_b), .enc_op2(enc_op2_b),
    .enc_done(enc_done_b), .ct_in(ct_in_b), .ct_valid(ct_valid_b), .ct_ready(ct_ready_b),
    .ct_data(ct_data_b), .ct_row(ct_row_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input int m, input int row, input int s);
    return (m == 0) ? 32'd1 : 32'(row * 100 + s);
  endfunction

  function automatic logic [31:0] exp_word(input int m, input int row, input logic [29:0] sub);
    logic [31:0] acc = 0;
    for (int s = 0; s < 30; s++) if (sub[s]) acc += word(m, row, s);
    return acc;
  endfunction

  function automatic logic [31:0] lane_sum(input logic [1:0][31:0] a, input logic [1:0][31:0] b);
    logic [31:0] acc = 0;
    for (int j = 0; j < 2; j++) begin
      if (!a[j][31]) acc += a[j];
      if (!b[j][31]) acc += b[j];
    end
    return acc;
  endfunction

  // key memory: data valid one cycle after mem_req, junk otherwise
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      mem_rdata[j*32 +: 32]   <= mem_req ? word(mode, int'(mem_row), int'(mem_chunk) * 4 + j) : $urandom();
      mem_rdata_b[j*32 +: 32] <= mem_req_b ? 32'd1 : $urandom();
    end
  end

  // accumulator: on a row change ct_in presents the old row's sum next cycle
  logic [31:0] acc_a, acc_b;
  logic [7:0]  acc_row_a, acc_row_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_a <= 0; acc_row_a <= 0; ct_in <= 0;
      acc_b <= 0; acc_row_b <= 0; ct_in_b <= 0;
    end else begin
      if (enc_row != acc_row_a) begin
        ct_in     <= acc_a;
        acc_row_a <= enc_row;
        acc_a     <= enc_en ? lane_sum(enc_op1, enc_op2) : 32'd0;
      end else begin
        acc_a <= enc_en ? acc_a + lane_sum(enc_op1, enc_op2) : 32'd0;
      end
      if (enc_row_b != acc_row_b) begin
        ct_in_b   <= acc_b;
        acc_row_b <= enc_row_b;
        acc_b     <= enc_en_b ? lane_sum(enc_op1_b, enc_op2_b) : 32'd0;
      end else begin
        acc_b <= enc_en_b ? acc_b + lane_sum(enc_op1_b, enc_op2_b) : 32'd0;
      end
    end
  end

  typedef struct { logic [31:0] data; logic [7:0] row; } exp_t;
  exp_t exp_q[$];

  int          words_total = 0;
  logic [31:0] row0_data   = 0;
  logic        hold_v      = 0;
  logic [31:0] hold_d      = 0;
  logic [7:0]  hold_r      = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", ct_valid, 1);
        check("hold_data", ct_data, hold_d);
        check("hold_row", ct_row, hold_r);
      end
      hold_v <= ct_valid && !ct_ready;
      hold_d <= ct_data;
      hold_r <= ct_row;
      if (ct_valid && ct_ready) begin
        words_total <= words_total + 1;
        if (ct_row == 8'd0) row0_data <= ct_data;
        if (exp_q.size() == 0) begin
          check("unexpected_word_row", ct_row, 8'hFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ct_data", ct_data, e.data);
          check("ct_row", ct_row, e.row);
        end
      end
    end
  end

  int words_b   = 0;
  int rowb_next = 0;
  always @(negedge clk) begin
    if (rst_n && ct_valid_b && ct_ready_b) begin
      check("b_ct_data", ct_data_b, 3);
      check("b_ct_row", ct_row_b, rowb_next);
      rowb_next <= rowb_next + 1;
      words_b   <= words_b + 1;
    end
  end

  typedef struct {
    int          mode;
    logic [29:0] subset;
    int          stall;
    bit          poke_start;
    int          exp_words;
    int          exp_req50;
    logic [31:0] exp_row0;
  } vec_t;
  vec_t vecs[4];

  task automatic push_expected(input int m, input logic [29:0] sub);
    for (int r = 0; r <= 128; r++) exp_q.push_back('{data: exp_word(m, r, sub), row: 8'(r)});
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, nreq, ndone, base;
    mode = v.mode;
    push_expected(v.mode, v.subset);
    base   = words_total;
    subset = v.subset;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    subset = ~v.subset;
    check("busy_after_start", busy, 1);
    cyc = 0; nreq = 0; ndone = 0;
    while (busy && cyc < 4000) begin
      ct_ready = (cyc >= v.stall);
      start    = v.poke_start && (cyc == 300 || cyc == 301);
      if (cyc < 50 && mem_req) nreq++;
      if (enc_done) begin
        ndone++;
        check("flush_enc_en", enc_en, 0);
        check("flush_enc_row", enc_row, 0);
      end
      if (v.stall > 0 && cyc >= 30 && cyc < v.stall) begin
        check("stall_mem_req", mem_req, 0);
        check("stall_enc_en", enc_en, 1);
      end
      if (v.stall > 0 && cyc == v.stall - 1) begin
        check("stall_head_valid", ct_valid, 1);
        check("stall_head_row", ct_row, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    ct_ready = 1'b1;
    check("run_finished", busy, 0);
    check("done_pulses", ndone, 1);
    check("req_first_50", nreq, v.exp_req50);
    repeat (6) @(posedge clk);
    #1;
    check("stays_idle", busy, 0);
    check("word_count", words_total - base, v.exp_words);
    check("row0_word", row0_data, v.exp_row0);
    check("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; subset = '0; ct_ready = 1'b0;
    start_b = 1'b0; subset_b = '0; ct_ready_b = 1'b0;

    vecs[0] = '{mode: 0, subset: 30'h3FFF_FFFF, stall: 0,  poke_start: 0, exp_words: 129, exp_req50: 50, exp_row0: 30};
    vecs[1] = '{mode: 1, subset: 30'h0000_0020, stall: 0,  poke_start: 0, exp_words: 129, exp_req50: 50, exp_row0: 5};
    vecs[2] = '{mode: 1, subset: 30'h3FFF_FFFF, stall: 50, poke_start: 0, exp_words: 129, exp_req50: 24, exp_row0: 435};
    vecs[3] = '{mode: 0, subset: 30'h2AAA_AAAA, stall: 0,  poke_start: 1, exp_words: 129, exp_req50: 50, exp_row0: 15};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_enc_en", enc_en, 0);
    check("rst_enc_done", enc_done, 0);
    check("rst_enc_row", enc_row, 0);
    check("rst_enc_op1", enc_op1, IDLE_LANES);
    check("rst_enc_op2", enc_op2, IDLE_LANES);
    check("rst_ct_valid", ct_valid, 0);
    check("rst_ct_data", ct_data, 0);
    check("rst_b_busy", busy_b, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // asynchronous reset in the middle of row 40
    mode = 0;
    push_expected(0, 30'h3FFF_FFFF);
    subset = 30'h3FFF_FFFF;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cyc = 0;
    while (enc_row != 8'd40 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_row40", enc_row, 40);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_mem_req", mem_req, 0);
    check("arst_mem_row", mem_row, 0);
    check("arst_enc_en", enc_en, 0);
    check("arst_enc_row", enc_row, 0);
    check("arst_enc_op1", enc_op1, IDLE_LANES);
    check("arst_ct_valid", ct_valid, 0);
    check("arst_ct_data", ct_data, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    // single chunk per row, consumer ready every other cycle
    subset_b = 4'b1011;
    start_b  = 1'b1;
    @(posedge clk); #1;
    start_b  = 1'b0;
    subset_b = 4'b0000;
    cyc = 0;
    while ((busy_b || ct_valid_b) && cyc < 3000) begin
      ct_ready_b = cyc[0];
      @(posedge clk); #1;
      cyc++;
    end
    ct_ready_b = 1'b0;
    check("b_run_finished", busy_b, 0);
    check("b_word_count", words_b, 129);
    check("b_last_row_next", rowb_next, 129);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
